riscv_instr_encoder_loader: RTL and testbench

//  Inverse of the instruction field parser: packs decoded RV32 fields (opcode, rd, rs1, rs2,

---
 rtl/riscv_instr_encoder_loader.sv | 157 +++++++++++++++
 tb/tb_riscv_instr_encoder_loader.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_instr_encoder_loader.sv
// Packs decoded RV32 instruction fields into 32-bit words and streams them
// sequentially into the instruction memory write port for the boot loader.
module riscv_instr_encoder_loader #(
    parameter int ADDR_W    = 8,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              fld_valid,
    output logic              fld_ready,
    input  logic              fld_last,
    input  logic [2:0]        fmt,
    input  logic [6:0]        opcode,
    input  logic [4:0]        rd,
    input  logic [4:0]        rs1,
    input  logic [4:0]        rs2,
    input  logic [2:0]        funct3,
    input  logic [6:0]        funct7,
    input  logic [31:0]       imm,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              fmt_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] BASE     = BASE_ADDR[ADDR_W-1:0];
    localparam logic [ADDR_W:0]   CAPACITY = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0]   LAST_IDX = {1'b0, {ADDR_W{1'b1}}};
    localparam logic [ADDR_W:0]   ONE      = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [31:0]       NOP_WORD = 32'h0000_0013;

    state_t state;
    state_t state_nxt;

    logic              accept;
    logic              fills_last;
    logic              fmt_bad;
    logic              vld_p1;
    logic [31:0]       word_p1;
    logic [ADDR_W-1:0] addr_p1;

    // Branch and jump immediates are byte offsets; bit 0 is implicitly zero
    // and is not encoded.
    function automatic logic [31:0] pack_word(
        input logic [2:0]  f,
        input logic [6:0]  op,
        input logic [4:0]  d,
        input logic [4:0]  r1,
        input logic [4:0]  r2,
        input logic [2:0]  f3,
        input logic [6:0]  f7,
        input logic [31:0] i
    );
        logic [31:0] w;
        case (f)
            3'd0:    w = {f7, r2, r1, f3, d, op};
            3'd1:    w = {i[11:0], r1, f3, d, op};
            3'd2:    w = {i[11:5], r2, r1, f3, i[4:0], op};
            3'd3:    w = {i[12], i[10:5], r2, r1, f3, i[4:1], i[11], op};
            3'd4:    w = {i[31:12], d, op};
            3'd5:    w = {i[20], i[10:1], i[11], i[19:12], d, op};
            default: w = NOP_WORD;
        endcase
        return w;
    endfunction

    assign fmt_bad    = fmt[2] & fmt[1];
    assign fills_last = (count == LAST_IDX);
    assign accept     = fld_valid && fld_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        fld_ready = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                busy      = 1'b1;
                fld_ready = (count < CAPACITY);
                if (fld_valid && fld_ready && (fld_last || fills_last)) begin
                    state_nxt = FLUSH;
                end
            end
            FLUSH: begin
                busy      = 1'b1;
                state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // p1: packed word registered one cycle after the accepting handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1   <= 1'b0;
            word_p1  <= 32'd0;
            addr_p1  <= BASE;
            count    <= '0;
            overflow <= 1'b0;
            fmt_err  <= 1'b0;
        end else begin
            vld_p1 <= accept;
            if (state == IDLE && start) begin
                count    <= '0;
                addr_p1  <= BASE;
                overflow <= 1'b0;
                fmt_err  <= 1'b0;
            end
            if (accept) begin
                word_p1 <= pack_word(fmt, opcode, rd, rs1, rs2, funct3, funct7, imm);
                addr_p1 <= BASE + count[ADDR_W-1:0];
                count   <= count + ONE;
                if (fmt_bad) begin
                    fmt_err <= 1'b1;
                end
                if (fills_last && !fld_last) begin
                    overflow <= 1'b1;
                end
            end
        end
    end

    // Reset kills a write that is already staged for this cycle.
    assign imem_we    = vld_p1 && !rst;
    assign imem_addr  = addr_p1;
    assign imem_wdata = word_p1;

endmodule

// File: tb/tb_riscv_instr_encoder_loader.sv
// Directed bench for the instruction encoder/loader: packing per format,
// write timing, session control, overflow and mid-session reset.
module tb_riscv_instr_encoder_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        fld_valid;
    logic        fld_last;
    logic [2:0]  fmt;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm;

    logic        fld_ready;
    logic        imem_we;
    logic [7:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic        busy;
    logic        done;
    logic [8:0]  count;
    logic        overflow;
    logic        fmt_err;

    logic        s_start;
    logic        s_valid;
    logic        s_ready;
    logic        s_we;
    logic [1:0]  s_addr;
    logic [31:0] s_wdata;
    logic        s_busy;
    logic        s_done;
    logic [2:0]  s_count;
    logic        s_overflow;
    logic        s_fmt_err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    riscv_instr_encoder_loader #(.ADDR_W(8), .BASE_ADDR(0)) dut (
        .clk(clk), .rst(rst), .start(start), .fld_valid(fld_valid),
        .fld_ready(fld_ready), .fld_last(fld_last), .fmt(fmt), .opcode(opcode),
        .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3), .funct7(funct7), .imm(imm),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .busy(busy), .done(done), .count(count), .overflow(overflow), .fmt_err(fmt_err)
    );

    riscv_instr_encoder_loader #(.ADDR_W(2), .BASE_ADDR(0)) dut_small (
        .clk(clk), .rst(rst), .start(s_start), .fld_valid(s_valid),
        .fld_ready(s_ready), .fld_last(fld_last), .fmt(fmt), .opcode(opcode),
        .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3), .funct7(funct7), .imm(imm),
        .imem_we(s_we), .imem_addr(s_addr), .imem_wdata(s_wdata),
        .busy(s_busy), .done(s_done), .count(s_count), .overflow(s_overflow),
        .fmt_err(s_fmt_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [2:0] f, input logic [6:0] op, input logic [4:0] d,
                        input logic [4:0] r1, input logic [4:0] r2, input logic [2:0] f3,
                        input logic [6:0] f7, input logic [31:0] i, input logic last);
        fld_valid = 1'b1;
        fmt = f; opcode = op; rd = d; rs1 = r1; rs2 = r2;
        funct3 = f3; funct7 = f7; imm = i; fld_last = last;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; fld_valid = 1'b0; fld_last = 1'b0;
        fmt = 3'd0; opcode = 7'd0; rd = 5'd0; rs1 = 5'd0; rs2 = 5'd0;
        funct3 = 3'd0; funct7 = 7'd0; imm = 32'd0;
        s_start = 1'b0; s_valid = 1'b0;
        tick();
        tick();
        chk("rst_we", imem_we, 0);
        chk("rst_addr", imem_addr, 0);
        chk("rst_wdata", imem_wdata, 0);
        chk("rst_count", count, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready", fld_ready, 0);
        chk("rst_done", done, 0);
        chk("rst_flags", {overflow, fmt_err}, 0);
        rst = 1'b0;

        // Session 1: mixed formats, back-to-back with one idle gap
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("s1_ready", fld_ready, 1);
        chk("s1_busy", busy, 1);
        send(3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 1'b0);
        tick();
        chk("r_we", imem_we, 1);
        chk("r_word", imem_wdata, 32'h002081B3);
        chk("r_addr", imem_addr, 0);
        chk("r_count", count, 1);
        send(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 1'b0);
        tick();
        chk("i_we", imem_we, 1);
        chk("i_word", imem_wdata, 32'h00500093);
        chk("i_addr", imem_addr, 1);
        send(3'd2, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8, 1'b0);
        tick();
        chk("s_we", imem_we, 1);
        chk("s_word", imem_wdata, 32'h0020A423);
        chk("s_addr", imem_addr, 2);
        fld_valid = 1'b0;
        tick();
        chk("gap_we", imem_we, 0);
        send(3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd9, 1'b0);
        tick();
        chk("b_word", imem_wdata, 32'h00208463);
        chk("b_addr", imem_addr, 3);
        send(3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd17, 1'b0);
        tick();
        chk("j_word", imem_wdata, 32'h010000EF);
        chk("j_addr", imem_addr, 4);
        send(3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000, 1'b1);
        tick();
        chk("u_we", imem_we, 1);
        chk("u_word", imem_wdata, 32'h123452B7);
        chk("u_addr", imem_addr, 5);
        chk("flush_ready", fld_ready, 0);
        chk("flush_busy", busy, 1);
        chk("flush_done", done, 0);
        fld_valid = 1'b0;
        fld_last  = 1'b0;
        tick();
        chk("s1_done", done, 1);
        chk("s1_done_busy", busy, 0);
        chk("s1_done_we", imem_we, 0);
        chk("s1_count", count, 6);
        tick();
        chk("s1_done_off", done, 0);
        chk("s1_count_hold", count, 6);
        chk("s1_no_err", {overflow, fmt_err}, 0);

        // Session 2: invalid format becomes a NOP and flags fmt_err
        start = 1'b1;
        tick();
        start = 1'b0;
        send(3'd7, 7'h33, 5'd3, 5'd1, 5'd2, 3'd5, 7'h20, 32'hFFFF_FFFF, 1'b1);
        tick();
        chk("bad_we", imem_we, 1);
        chk("bad_word", imem_wdata, 32'h00000013);
        chk("bad_addr", imem_addr, 0);
        chk("bad_flag", fmt_err, 1);
        chk("bad_count", count, 1);
        fld_valid = 1'b0;
        fld_last  = 1'b0;
        tick();
        chk("bad_done", done, 1);
        tick();
        chk("bad_flag_hold", fmt_err, 1);

        // Session 3: reset right after an accept drops the staged write
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("s3_flag_clear", fmt_err, 0);
        chk("s3_count_clear", count, 0);
        send(3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 1'b0);
        tick();
        rst = 1'b1;
        fld_valid = 1'b0;
        #1;
        chk("abort_we", imem_we, 0);
        tick();
        rst = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_count", count, 0);
        chk("abort_we2", imem_we, 0);
        chk("abort_ready", fld_ready, 0);

        // Small memory: four words fill it, the fifth bundle is refused
        s_start = 1'b1;
        tick();
        s_start = 1'b0;
        send(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1, 1'b0);
        fld_valid = 1'b0;
        s_valid   = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("ovf_we", s_we, 1);
            chk("ovf_addr", s_addr, k);
        end
        chk("ovf_ready", s_ready, 0);
        chk("ovf_flag", s_overflow, 1);
        chk("ovf_count", s_count, 4);
        tick();
        chk("ovf_5th_we", s_we, 0);
        chk("ovf_done", s_done, 1);
        s_valid = 1'b0;
        tick();
        chk("ovf_done_off", s_done, 0);
        chk("ovf_count_hold", s_count, 4);
        chk("ovf_flag_hold", s_overflow, 1);
        chk("main_quiet", imem_we, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
